// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter and sequencer for the single memory port.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of data-over-fetch priority.
module mem_port_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    input  logic        d_req_wr,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          own_d_q;
    logic [31:0]   mem_addr_q, mem_wr_data_q, if_rsp_data_q, d_rsp_data_q;
    logic          mem_wr_en_q, if_rsp_valid_q, d_rsp_valid_q;
    logic          gnt_d, gnt_if, accept, capture;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;  // 1 = data won the previous handshake

    always_comb begin
        gnt_d = d_req_valid;
        if (d_req_valid && if_req_valid)
            gnt_d = !last_d_q;
    end
`else
    always_comb begin
        gnt_d = d_req_valid;
    end
`endif

    assign gnt_if       = if_req_valid && !gnt_d;
    assign accept       = rst && (state_q == IDLE) && (gnt_d || gnt_if);
    assign d_req_ready  = rst && (state_q == IDLE) && gnt_d;
    assign if_req_ready = rst && (state_q == IDLE) && gnt_if;

    // Read data is sampled at the end of the RD_LATENCY-th cycle after the handshake.
    assign capture = ((state_q == ISSUE) && !mem_wr_en_q && (CNT_INIT == '0)) ||
                     ((state_q == WAIT) && (cnt_q == CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            own_d_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_wr_en_q    <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q       <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        own_d_q       <= gnt_d;
                        mem_addr_q    <= gnt_d ? d_req_addr : if_req_addr;
                        mem_wr_data_q <= gnt_d ? d_req_wdata : 32'h0;
                        mem_wr_en_q   <= gnt_d && d_req_wr;
                        state_q       <= ISSUE;
`ifdef MEM_ARB_RR_EN
                        last_d_q      <= gnt_d;
`endif
                    end
                end
                ISSUE: begin
                    mem_wr_en_q <= 1'b0;
                    if (mem_wr_en_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_data_q  <= '0;
                        state_q       <= RESP;
                    end else if (CNT_INIT == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1))
                        state_q <= RESP;
                    else
                        cnt_q <= cnt_q - CW'(1);
                end
                RESP: begin
                    if_rsp_valid_q <= 1'b0;
                    d_rsp_valid_q  <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (capture) begin
                if (own_d_q) begin
                    d_rsp_valid_q <= 1'b1;
                    d_rsp_data_q  <= mem_rd_data;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_data_q  <= mem_rd_data;
                end
            end
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (RD_LATENCY 1, 2, 4) share stimulus,
// each backed by a memory whose read data only becomes valid RD_LATENCY-1 cycles after the address.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req_valid, d_req_valid, d_req_wr;
    logic [31:0] if_req_addr, d_req_addr, d_req_wdata;

    logic        if_rdy [3], if_rv [3], d_rdy [3], d_rv [3], wen [3];
    logic [31:0] if_rd [3], d_rd [3], maddr [3], mwd [3], mrd [3];

    int nvec = 0;
    int nerr = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return a ^ 32'hA5C30F00;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [31:0] p [3];

        always @(posedge clk) begin
            p[0] <= memf(maddr[g]);
            p[1] <= p[0];
            p[2] <= p[1];
        end
        assign mrd[g] = (LAT == 1) ? memf(maddr[g]) : p[LAT-2];

        mem_port_arbiter #(.RD_LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
            .if_req_ready(if_rdy[g]), .if_rsp_valid(if_rv[g]), .if_rsp_data(if_rd[g]),
            .d_req_valid(d_req_valid), .d_req_wr(d_req_wr), .d_req_addr(d_req_addr),
            .d_req_wdata(d_req_wdata), .d_req_ready(d_rdy[g]),
            .d_rsp_valid(d_rv[g]), .d_rsp_data(d_rd[g]),
            .mem_addr(maddr[g]), .mem_wr_en(wen[g]), .mem_wr_data(mwd[g]),
            .mem_rd_data(mrd[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid  = 1'b0; d_req_wr = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    endtask

    task automatic reset_all();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            nvec++;
            if ({if_rdy[g], d_rdy[g], if_rv[g], d_rv[g], wen[g]} !== 5'b0) begin
                nerr++;
                $display("FAIL reset_ctrl[%0d]: got %b exp 00000", g, {if_rdy[g], d_rdy[g], if_rv[g], d_rv[g], wen[g]});
            end
            nvec++;
            if ((maddr[g] | mwd[g] | if_rd[g] | d_rd[g]) !== 32'h0) begin
                nerr++;
                $display("FAIL reset_data[%0d]: got addr %h wd %h ird %h drd %h exp 0", g, maddr[g], mwd[g], if_rd[g], d_rd[g]);
            end
        end
        idle_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_fetch_lat2();
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        @(negedge clk);
        nvec++;
        if ({if_rdy[1], d_rdy[1]} !== 2'b10) begin
            nerr++; $display("FAIL fetch_ready_c0: got %b exp 10", {if_rdy[1], d_rdy[1]});
        end
        tick();
        if_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            nvec++;
            if (if_rv[1] !== (c == 3)) begin
                nerr++; $display("FAIL fetch_rsp_valid_c%0d: got %b exp %b", c, if_rv[1], (c == 3));
            end
            if (c < 3) begin
                nvec++;
                if (maddr[1] !== 32'h10 || wen[1] !== 1'b0) begin
                    nerr++; $display("FAIL fetch_addr_c%0d: got %h/%b exp 00000010/0", c, maddr[1], wen[1]);
                end
            end else begin
                nvec++;
                if (if_rd[1] !== 32'hDEADBEEF) begin
                    nerr++; $display("FAIL fetch_data: got %h exp deadbeef", if_rd[1]);
                end
            end
            tick();
        end
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        @(negedge clk);
        nvec++;
        if ({if_rdy[1], if_rv[1]} !== 2'b10) begin
            nerr++; $display("FAIL fetch_c4: got rdy/rsp %b exp 10", {if_rdy[1], if_rv[1]});
        end
        reset_all();
    endtask

    task automatic test_store();
        tick();
        d_req_valid = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h10; d_req_wdata = 32'h0;
        tick();
        d_req_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        nvec++;
        if (d_rv[1] !== 1'b1 || d_rd[1] !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL load_before_store: got %b/%h exp 1/deadbeef", d_rv[1], d_rd[1]);
        end
        tick();
        d_req_valid = 1'b1; d_req_wr = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h12345678;
        @(negedge clk);
        nvec++;
        if (d_rdy[1] !== 1'b1 || wen[1] !== 1'b0) begin
            nerr++; $display("FAIL store_c0: got rdy %b wen %b exp 1 0", d_rdy[1], wen[1]);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        nvec++;
        if (wen[1] !== 1'b1 || maddr[1] !== 32'h20 || mwd[1] !== 32'h12345678 || d_rv[1] !== 1'b0) begin
            nerr++; $display("FAIL store_c1: got wen %b addr %h wd %h rsp %b exp 1 20 12345678 0", wen[1], maddr[1], mwd[1], d_rv[1]);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (wen[1] !== 1'b0 || d_rv[1] !== 1'b1 || d_rd[1] !== 32'h0) begin
            nerr++; $display("FAIL store_c2: got wen %b rsp %b data %h exp 0 1 0", wen[1], d_rv[1], d_rd[1]);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (d_rv[1] !== 1'b0) begin
            nerr++; $display("FAIL store_c3: got rsp %b exp 0", d_rv[1]);
        end
        reset_all();
    endtask

    task automatic test_tie();
        logic exp_seq [4];
        logic seq [4];
        int   n = 0;
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        seq = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        d_req_valid  = 1'b1; d_req_addr  = 32'h200; d_req_wr = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            nvec++;
            if (if_rdy[1] && d_rdy[1]) begin
                nerr++; $display("FAIL tie_both_ready_c%0d: got 11 exp one-hot", c);
            end
            if ((if_rdy[1] || d_rdy[1]) && n < 4) begin
                seq[n] = d_rdy[1];
                n++;
            end
            tick();
        end
        nvec++;
        if (n !== 4) begin
            nerr++; $display("FAIL tie_grant_count: got %0d exp 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (seq[i] !== exp_seq[i]) begin
                nerr++; $display("FAIL tie_grant%0d: got data=%b exp data=%b", i, seq[i], exp_seq[i]);
            end
        end
        reset_all();
    endtask

    task automatic test_reset_mid();
        tick();
        d_req_valid = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h40; d_req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        nvec++;
        if (d_rdy[2] !== 1'b1) begin
            nerr++; $display("FAIL rmid_accept: got %b exp 1", d_rdy[2]);
        end
        tick();
        d_req_valid = 1'b0;
        tick();
        nvec++;
        if (maddr[2] !== 32'h40 || mwd[2] !== 32'hCAFEF00D) begin
            nerr++; $display("FAIL rmid_wait_addr: got %h/%h exp 40/cafef00d", maddr[2], mwd[2]);
        end
        d_req_valid = 1'b1;
        rst = 1'b0;
        #1;
        nvec++;
        if ({d_rdy[2], d_rv[2], if_rv[2], wen[2]} !== 4'b0 ||
            (maddr[2] | mwd[2] | d_rd[2] | if_rd[2]) !== 32'h0) begin
            nerr++; $display("FAIL rmid_outputs_zero: got ctl %b addr %h wd %h exp 0", {d_rdy[2], d_rv[2], if_rv[2], wen[2]}, maddr[2], mwd[2]);
        end
        d_req_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h44;
        @(negedge clk);
        nvec++;
        if (d_rdy[2] !== 1'b1) begin
            nerr++; $display("FAIL rmid_first_accept: got %b exp 1", d_rdy[2]);
        end
        tick();
        d_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            nvec++;
            if (d_rv[2] !== (c == 5)) begin
                nerr++; $display("FAIL rmid_rsp_c%0d: got %b exp %b", c, d_rv[2], (c == 5));
            end
            if (c == 5) begin
                nvec++;
                if (d_rd[2] !== 32'hA5C30F44) begin
                    nerr++; $display("FAIL rmid_data: got %h exp a5c30f44", d_rd[2]);
                end
            end
            tick();
        end
        reset_all();
    endtask

    task automatic test_back_to_back();
        int       idx = 0;
        logic     hs;
        logic [31:0] exp_d;
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            nvec++;
            if (if_rdy[0] !== ((c % 3 == 0) && c <= 6)) begin
                nerr++; $display("FAIL b2b_ready_c%0d: got %b exp %b", c, if_rdy[0], ((c % 3 == 0) && c <= 6));
            end
            nvec++;
            if (if_rv[0] !== (c == 2 || c == 5 || c == 8)) begin
                nerr++; $display("FAIL b2b_rsp_c%0d: got %b exp %b", c, if_rv[0], (c == 2 || c == 5 || c == 8));
            end
            if (c == 2 || c == 5 || c == 8) begin
                exp_d = memf(32'((c - 2) / 3));
                nvec++;
                if (if_rd[0] !== exp_d) begin
                    nerr++; $display("FAIL b2b_data_c%0d: got %h exp %h", c, if_rd[0], exp_d);
                end
            end
            hs = if_rdy[0] && if_req_valid;
            tick();
            if (hs) begin
                idx++;
                if (idx < 3) if_req_addr = 32'(idx);
                else         if_req_valid = 1'b0;
            end
        end
        reset_all();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_lat2();
        test_store();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the processor's single memory port (mem_addr / mem_wr_en / mem_wr_data / mem_rd_data).
- Instruction fetch and data load/store each present a valid/ready request channel.
- The block grants one transaction at a time, drives the shared memory port, waits the fixed memory read latency, and returns a one-cycle response pulse to the owner.
- It sits between the core pipeline and the memory model.

## Interface
Parameters:
- RD_LATENCY, 1, cycles from mem_addr presented to mem_rd_data valid; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch read data valid, single-cycle pulse
- if_rsp_data  out  32  fetch read data
- d_req_valid  in  1  data request
- d_req_wr  in  1  1 = store, 0 = load
- d_req_addr  in  32  data address
- d_req_wdata  in  32  store data
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  load data valid / store done, single-cycle pulse
- d_rsp_data  out  32  load data; 0 for stores
- mem_addr  out  32  memory address
- mem_wr_en  out  1  memory write strobe
- mem_wr_data  out  32  memory write data
- mem_rd_data  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, select a winner and assert that port's req_ready combinationally in the same cycle. The loser's ready stays 0.
  - Handshake (valid & ready): latch addr, wr, wdata and owner, then go to ISSUE.
  - Payload is sampled only at the handshake.
  - A fetch request always counts as wr = 0.
- **ISSUE** (1 cycle)
  - mem_addr = latched addr.
  - mem_wr_en = latched wr.
  - mem_wr_data = latched wdata.
  - Write: go to RESP.
  - Read: load latency counter with RD_LATENCY-1.
    - If the counter value is 0 (RD_LATENCY = 1), capture mem_rd_data at the end of ISSUE and go to RESP.
    - Otherwise go to WAIT.
- **WAIT**
  - mem_addr held; mem_wr_en = 0.
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, capture mem_rd_data and go to RESP.
  - Net effect: data is captured exactly RD_LATENCY cycles after ISSUE.
- **RESP** (1 cycle)
  - Owner's rsp_valid = 1 with the captured data; d_rsp_data = 0 for stores. Then go to IDLE.
  - No requests are accepted in RESP.
- Responses have no backpressure; requesters must take the pulse.
- Only one transaction is in flight at a time; ready is never asserted outside IDLE.
- Arbitration without the macro: fixed priority, data over fetch.
- mem_addr and mem_wr_data hold their last value in IDLE, WAIT and RESP. mem_wr_en is 1 only in ISSUE of a store.
- Counter width is $clog2(RD_LATENCY+1).

## Timing
- Reset values: state IDLE; all outputs 0, including mem_addr, mem_wr_data, rsp_data and the RR pointer (last grant = data).
- Reset assertion mid-transaction takes effect immediately and asynchronously:
  - All outputs drop to 0 and the in-flight transaction is discarded.
  - No response is ever issued for it.
- Reset deassertion: the first acceptance can occur in the first clock cycle after release.
- Load, handshake in cycle 0: ISSUE in cycle 1, capture in cycle 1+RD_LATENCY-1… precisely at end of cycle RD_LATENCY, rsp_valid in cycle RD_LATENCY+1, next acceptance in cycle RD_LATENCY+2.
  - RD_LATENCY = 1: ISSUE cycle 1, RESP cycle 2, IDLE cycle 3.
- Store, handshake in cycle 0: ISSUE (mem_wr_en) in cycle 1, d_rsp_valid in cycle 2, IDLE in cycle 3.
- Simultaneous valids in IDLE: exactly one ready is asserted. The losing valid must be held by its requester; it is served on a later IDLE.
- A valid that drops before its handshake has no effect.

## Configuration
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A one-bit last-grant register is updated on each handshake.
  - On a tie, the port not granted last wins.
  - Reset value = data, so the first tie after reset goes to fetch.
- Undefined: fixed data-over-fetch priority; the last-grant register is not present.
- A lone requester is granted identically in both builds.

## Test plan
- **Fetch read, RD_LATENCY = 2:** memory returns 0xDEADBEEF for address 0x10; if_req_valid with addr 0x10 in cycle 0 -> if_req_ready = 1 in cycle 0, mem_addr = 0x10 in cycles 1–2, if_rsp_valid = 1 with data 0xDEADBEEF in cycle 3 only, if_req_ready next possible in cycle 4.
- **Store:** d_req_wr = 1, addr 0x20, wdata 0x12345678 -> mem_wr_en = 1 only in cycle 1 with mem_addr 0x20 and mem_wr_data 0x12345678; d_rsp_valid = 1 with d_rsp_data = 0 in cycle 2.
- **Tie, macro undefined:** both valid constantly -> every grant goes to data; fetch is never granted.
- **Tie, MEM_ARB_RR_EN defined:** both valid constantly -> grants alternate fetch, data, fetch, data starting from reset.
- **Reset mid-WAIT, RD_LATENCY = 4:** assert rst low in cycle 2 after a load handshake -> all outputs 0 immediately. After release, no d_rsp_valid appears and a new request is accepted in the first cycle.
- **RD_LATENCY = 1 back-to-back fetches** to 0x0, 0x1, 0x2 -> three if_rsp_valid pulses, 3 cycles apart, with the data returned for each address.
